// File: rtl/sample_pkg.sv
// Shared types and constants for the sample datapath sweep sequencer.
package sample_pkg;

    localparam int MAX_VEC = 8;
    localparam int ABC_W   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/sample_dwell_cnt.sv
// Dwell counter: counts up from zero while enabled, flags the last cycle of a dwell.
module sample_dwell_cnt #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               en,
    input  logic [DWELL_W-1:0] limit,
    output logic [DWELL_W-1:0] cnt,
    output logic               tc
);

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    // limit is never zero, so limit-1 cannot wrap
    assign tc = (cnt == limit - 1'b1);

endmodule

// File: rtl/sample_sweep_ctrl.sv
// Steps the sample datapath through NUM_VEC input vectors, captures D/E at the
// end of each dwell and compares against a latched expected table.
module sample_sweep_ctrl
    import sample_pkg::*;
#(
    parameter int NUM_VEC = 8,
    parameter int DWELL_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [DWELL_W-1:0]   dwell,
    input  logic [2*NUM_VEC-1:0] exp_table,
    output logic [ABC_W-1:0]     abc_out,
    input  logic [1:0]           de_in,
    output logic                 busy,
    output logic                 done,
    output logic [2*NUM_VEC-1:0] result,
    output logic [NUM_VEC-1:0]   err_mask,
    output logic                 pass
);

    localparam logic [ABC_W-1:0] LAST_VEC = ABC_W'(NUM_VEC - 1);

    state_t               state;
    logic [ABC_W-1:0]     vec;
    logic [DWELL_W-1:0]   dwell_eff;
    logic [2*NUM_VEC-1:0] exp_q;
    logic [DWELL_W-1:0]   cnt;
    logic                 tc;
    logic [2*NUM_VEC-1:0] res_cap;
    logic [NUM_VEC-1:0]   err_cap;

    sample_dwell_cnt #(.DWELL_W(DWELL_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   ((state != DRIVE) || tc || abort),
        .en    (state == DRIVE),
        .limit (dwell_eff),
        .cnt   (cnt),
        .tc    (tc)
    );

    // result/err_mask as they would look after capturing the current vector
    always_comb begin
        res_cap = result;
        err_cap = err_mask;
        for (int i = 0; i < NUM_VEC; i++) begin
            if (vec == ABC_W'(i)) begin
                res_cap[2*i +: 2] = de_in;
                err_cap[i]        = (de_in != exp_q[2*i +: 2]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            vec       <= '0;
            abc_out   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            err_mask  <= '0;
            pass      <= 1'b0;
            dwell_eff <= DWELL_W'(1);
            exp_q     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dwell_eff <= (dwell == '0) ? DWELL_W'(1) : dwell;
                        exp_q     <= exp_table;
                        result    <= '0;
                        err_mask  <= '0;
                        pass      <= 1'b0;
                        vec       <= '0;
                        abc_out   <= '0;
                        busy      <= 1'b1;
                        state     <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (abort) begin
                        state   <= IDLE;
                        abc_out <= '0;
                        busy    <= 1'b0;
                        pass    <= 1'b0;
                    end else if (tc) begin
                        result   <= res_cap;
                        err_mask <= err_cap;
                        if (vec == LAST_VEC) begin
                            state   <= DONE;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            abc_out <= '0;
                            pass    <= ~|err_cap;
                        end else begin
                            vec     <= vec + 1'b1;
                            abc_out <= vec + 1'b1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sample_sweep_ctrl.sv
// Directed bench for sample_sweep_ctrl with a combinational D=A&B, E=B|C datapath model.
module tb_sample_sweep_ctrl;

    localparam int NV = 8;
    localparam int DW = 8;
    // {D,E} per vector from D=A&B, E=B|C with {A,B,C}=i: 11,11,01,00,01,01,01,00
    localparam logic [15:0] GOOD = 16'hF454;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [DW-1:0] dwell;
    logic [15:0]   exp_table;
    logic [2:0]    abc_out;
    logic [1:0]    de_in;
    logic          busy;
    logic          done;
    logic [15:0]   result;
    logic [7:0]    err_mask;
    logic          pass;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign de_in = {abc_out[2] & abc_out[1], abc_out[1] | abc_out[0]};

    sample_sweep_ctrl #(.NUM_VEC(NV), .DWELL_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .dwell     (dwell),
        .exp_table (exp_table),
        .abc_out   (abc_out),
        .de_in     (de_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .err_mask  (err_mask),
        .pass      (pass)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_abc"},  32'(abc_out), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_res"},  32'(result), 0);
        chk({tag, "_err"},  32'(err_mask), 0);
        chk({tag, "_pass"}, 32'(pass), 0);
    endtask

    task automatic sweep(input logic [DW-1:0] dw, input logic [15:0] tbl,
                         input logic [15:0] want_res, input logic [7:0] want_err);
        int d;
        d = (dw == 0) ? 1 : int'(dw);
        dwell = dw;
        exp_table = tbl;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < NV*d; k++) begin
            chk("abc_step", 32'(abc_out), 32'(k / d));
            chk("busy_drive", 32'(busy), 1);
            chk("done_early", 32'(done), 0);
            tick();
        end
        chk("done_pulse", 32'(done), 1);
        chk("busy_done", 32'(busy), 0);
        chk("abc_done", 32'(abc_out), 0);
        chk("result", 32'(result), 32'(want_res));
        chk("err_mask", 32'(err_mask), 32'(want_err));
        chk("pass", 32'(pass), (want_err == 0) ? 1 : 0);
        tick();
        chk("done_one_cycle", 32'(done), 0);
        chk("pass_hold", 32'(pass), (want_err == 0) ? 1 : 0);
        chk("result_hold", 32'(result), 32'(want_res));
    endtask

    initial begin
        logic seen_done;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        dwell = 8'd3;
        exp_table = GOOD;
        tick();
        tick();
        chk_idle_zero("reset");
        rst_n = 1'b1;
        tick();

        // clean sweep, then a table with vector 2 flipped
        sweep(8'd3, GOOD, GOOD, 8'h00);
        tick();
        sweep(8'd3, GOOD ^ 16'h0020, GOOD, 8'h04);
        tick();

        // abort during vector 2's capture cycle (cycle 8 with dwell 3)
        dwell = 8'd3;
        exp_table = GOOD;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        chk("abort_pre_abc", 32'(abc_out), 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_abc", 32'(abc_out), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_result", 32'(result), 32'h0004);
        chk("abort_err", 32'(err_mask), 0);
        chk("abort_pass", 32'(pass), 0);
        seen_done = 1'b0;
        repeat (30) begin
            if (done) seen_done = 1'b1;
            tick();
        end
        chk("abort_no_done", 32'(seen_done), 0);
        chk("abort_still_idle", 32'(busy), 0);

        // dwell 0 behaves as dwell 1
        sweep(8'd0, GOOD, GOOD, 8'h00);
        tick();

        // second start mid-sweep is ignored, then reset mid-sweep
        dwell = 8'd3;
        exp_table = GOOD;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (k == 4) begin
                start = 1'b1;
                dwell = 8'd1;
                exp_table = 16'h0000;
            end
            if (k == 5) start = 1'b0;
            chk("restart_ignored_abc", 32'(abc_out), 32'(k / 3));
            tick();
        end
        chk("pre_reset_busy", 32'(busy), 1);
        chk("pre_reset_result", 32'(result), 32'h0054);
        rst_n = 1'b0;
        tick();
        chk_idle_zero("midreset");
        rst_n = 1'b1;
        tick();
        sweep(8'd2, GOOD, GOOD, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
